// File: rtl/fluxo_dados_genius_n.sv
// Datapath of the memory-sequence game: address/limit counters, play register,
// sequence RAM, press edge detector, idle timeout and display timer.
module fluxo_dados_genius_n #(
  parameter int NB          = 4,
  parameter int DEPTH       = 16,
  parameter int AW          = $clog2(DEPTH),
  parameter int TIMEOUT_CYC = 5000,
  parameter int TMR_CYC     = 500
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [NB-1:0] botoes,
  input  logic          zeraE,
  input  logic          contaE,
  input  logic          zeraL,
  input  logic          contaL,
  input  logic          zeraR,
  input  logic          registraR,
  input  logic          escreveM,
  input  logic          zeraTMR,
  input  logic          contaTMR,
  output logic          fimE,
  output logic          fimL,
  output logic          fimTMR,
  output logic          jogada_feita,
  output logic          jogada_invalida,
  output logic          chavesIgualMemoria,
  output logic          enderecoIgualLimite,
  output logic          enderecoMenorOuIgualLimite,
  output logic          timeout,
  output logic [NB-1:0] db_jogada,
  output logic [NB-1:0] db_memoria,
  output logic [AW-1:0] db_contagem,
  output logic [AW-1:0] db_limite,
  output logic          db_tem_jogada
);

  localparam int IW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TW = (TMR_CYC > 1) ? $clog2(TMR_CYC) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [IW-1:0] IDLE_PRE  = IW'(TIMEOUT_CYC - 2);
  localparam logic [TW-1:0] TMR_LAST  = TW'(TMR_CYC - 1);

  logic [AW-1:0] endereco;
  logic [AW-1:0] limite;
  logic [NB-1:0] jogada;
  logic [NB-1:0] mem_q;
  logic [NB-1:0] mem [DEPTH];
  logic          tem;
  logic          prev;
  logic [IW-1:0] idle_cnt;
  logic          idle_clr;
  logic [TW-1:0] tmr;

  // More than one bit set: clearing the lowest set bit leaves something behind.
  function automatic logic multi_hot(input logic [NB-1:0] b);
    return (b & (b - NB'(1))) != '0;
  endfunction

  always_ff @(posedge clock) begin
    if (reset || zeraE)
      endereco <= '0;
    else if (contaE)
      endereco <= (endereco == LAST_ADDR) ? '0 : endereco + AW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset || zeraL)
      limite <= '0;
    else if (contaL)
      limite <= (limite == LAST_ADDR) ? '0 : limite + AW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset || zeraR)
      jogada <= '0;
    else if (registraR)
      jogada <= botoes;
  end

  // RAM array holds its contents across reset; only the read register clears.
  always_ff @(posedge clock) begin
    if (escreveM)
      mem[endereco] <= jogada;
  end

  always_ff @(posedge clock) begin
    if (reset)
      mem_q <= '0;
    else if (escreveM)
      mem_q <= jogada;
    else
      mem_q <= mem[endereco];
  end

  assign tem             = |botoes;
  assign jogada_feita    = tem & ~prev;
  assign jogada_invalida = jogada_feita & multi_hot(botoes);

  always_ff @(posedge clock) begin
    if (reset)
      prev <= 1'b0;
    else
      prev <= tem;
  end

  // Idle counter stops once timeout is raised, so the flag stays until a clear.
  assign idle_clr = reset | zeraE | contaE | jogada_feita;

  always_ff @(posedge clock) begin
    if (idle_clr) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (!tem && !timeout) begin
      idle_cnt <= idle_cnt + IW'(1);
      if (idle_cnt == IDLE_PRE)
        timeout <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || zeraTMR)
      tmr <= '0;
    else if (contaTMR)
      tmr <= (tmr == TMR_LAST) ? '0 : tmr + TW'(1);
  end

  assign fimE                       = (endereco == LAST_ADDR);
  assign fimL                       = (limite == LAST_ADDR);
  assign fimTMR                     = (tmr == TMR_LAST);
  assign chavesIgualMemoria         = (jogada == mem_q);
  assign enderecoIgualLimite        = (endereco == limite);
  assign enderecoMenorOuIgualLimite = (endereco <= limite);

  assign db_jogada     = jogada;
  assign db_memoria    = mem_q;
  assign db_contagem   = endereco;
  assign db_limite     = limite;
  assign db_tem_jogada = tem;

endmodule

// File: tb/tb_fluxo_dados_genius_n.sv
// Bench for fluxo_dados_genius_n: directed game scenarios plus random strobes,
// every cycle compared against a behavioural model of the game datapath.
module tb_fluxo_dados_genius_n;

  localparam int NB = 4, DEPTH = 8, AW = 3, TIMEOUT_CYC = 20, TMR_CYC = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] botoes = '0;
  logic          zeraE = 0, contaE = 0, zeraL = 0, contaL = 0, zeraR = 0, registraR = 0;
  logic          escreveM = 0, zeraTMR = 0, contaTMR = 0;
  logic          fimE, fimL, fimTMR, jogada_feita, jogada_invalida, chavesIgualMemoria;
  logic          enderecoIgualLimite, enderecoMenorOuIgualLimite, timeout, db_tem_jogada;
  logic [NB-1:0] db_jogada, db_memoria;
  logic [AW-1:0] db_contagem, db_limite;

  fluxo_dados_genius_n #(.NB(NB), .DEPTH(DEPTH), .AW(AW), .TIMEOUT_CYC(TIMEOUT_CYC),
                         .TMR_CYC(TMR_CYC)) dut (
    .clock(clock), .reset(reset), .botoes(botoes),
    .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
    .zeraR(zeraR), .registraR(registraR), .escreveM(escreveM),
    .zeraTMR(zeraTMR), .contaTMR(contaTMR),
    .fimE(fimE), .fimL(fimL), .fimTMR(fimTMR),
    .jogada_feita(jogada_feita), .jogada_invalida(jogada_invalida),
    .chavesIgualMemoria(chavesIgualMemoria), .enderecoIgualLimite(enderecoIgualLimite),
    .enderecoMenorOuIgualLimite(enderecoMenorOuIgualLimite), .timeout(timeout),
    .db_jogada(db_jogada), .db_memoria(db_memoria), .db_contagem(db_contagem),
    .db_limite(db_limite), .db_tem_jogada(db_tem_jogada)
  );

  always #5 clock = ~clock;

  int n_vec = 0, n_err = 0;

  // Game state as plain integers
  int m_addr, m_lim, m_jog, m_rd, m_idle, m_tmr;
  bit m_rd_ok, m_prev, m_tmo;
  int m_mem [DEPTH];
  bit m_mem_ok [DEPTH];

  bit obs_feita, obs_inv, obs_tem;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr = 0; m_lim = 0; m_jog = 0; m_rd = 0; m_rd_ok = 1;
    m_prev = 0; m_idle = 0; m_tmo = 0; m_tmr = 0;
  endtask

  task automatic check_all();
    bit tem, pulse;
    tem   = (botoes != 0);
    pulse = tem && !m_prev;
    check("jogada_feita", int'(jogada_feita), int'(pulse));
    check("jogada_invalida", int'(jogada_invalida), int'(pulse && $countones(botoes) > 1));
    check("db_tem_jogada", int'(db_tem_jogada), int'(tem));
    check("db_contagem", int'(db_contagem), m_addr);
    check("db_limite", int'(db_limite), m_lim);
    check("db_jogada", int'(db_jogada), m_jog);
    check("fimE", int'(fimE), int'(m_addr == DEPTH - 1));
    check("fimL", int'(fimL), int'(m_lim == DEPTH - 1));
    check("fimTMR", int'(fimTMR), int'(m_tmr == TMR_CYC - 1));
    check("enderecoIgualLimite", int'(enderecoIgualLimite), int'(m_addr == m_lim));
    check("enderecoMenorOuIgualLimite", int'(enderecoMenorOuIgualLimite), int'(m_addr <= m_lim));
    check("timeout", int'(timeout), int'(m_tmo));
    if (m_rd_ok) begin
      check("db_memoria", int'(db_memoria), m_rd);
      check("chavesIgualMemoria", int'(chavesIgualMemoria), int'(m_jog == m_rd));
    end
  endtask

  task automatic model_next();
    bit tem, pulse;
    tem   = (botoes != 0);
    pulse = tem && !m_prev;
    if (reset) begin
      if (escreveM) begin m_mem[m_addr] = m_jog; m_mem_ok[m_addr] = 1; end
      model_reset();
    end else begin
      if (escreveM) begin
        m_rd = m_jog; m_rd_ok = 1;
        m_mem[m_addr] = m_jog; m_mem_ok[m_addr] = 1;
      end else begin
        m_rd = m_mem[m_addr]; m_rd_ok = m_mem_ok[m_addr];
      end
      if (zeraE) m_addr = 0; else if (contaE) m_addr = (m_addr + 1) % DEPTH;
      if (zeraL) m_lim = 0; else if (contaL) m_lim = (m_lim + 1) % DEPTH;
      if (zeraR) m_jog = 0; else if (registraR) m_jog = int'(botoes);
      if (zeraE || contaE || pulse) begin
        m_idle = 0; m_tmo = 0;
      end else if (!tem && !m_tmo) begin
        m_idle++;
        if (m_idle == TIMEOUT_CYC - 1) m_tmo = 1;
      end
      if (zeraTMR) m_tmr = 0; else if (contaTMR) m_tmr = (m_tmr + 1) % TMR_CYC;
      m_prev = tem;
    end
  endtask

  // One clock: check at the falling edge, then advance model across the rising edge.
  task automatic step();
    @(negedge clock);
    obs_feita = jogada_feita; obs_inv = jogada_invalida; obs_tem = db_tem_jogada;
    check_all();
    model_next();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    zeraE = 0; contaE = 0; zeraL = 0; contaL = 0; zeraR = 0; registraR = 0;
    escreveM = 0; zeraTMR = 0; contaTMR = 0;
  endtask

  initial begin
    int pc, ic, tc;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 0; m_mem_ok[i] = 0; end
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    step();
    check("rst_chaves", int'(chavesIgualMemoria), 1);
    check("rst_eq", int'(enderecoIgualLimite), 1);
    check("rst_le", int'(enderecoMenorOuIgualLimite), 1);
    check("rst_timeout", int'(timeout), 0);
    reset = 0;
    step();

    // Single press held 3 cycles
    botoes = 4'b0001; pc = 0; ic = 0; tc = 0;
    repeat (3) begin step(); pc += obs_feita; ic += obs_inv; tc += obs_tem; end
    check("single_pulse_count", pc, 1);
    check("single_invalid_count", ic, 0);
    check("single_tem_count", tc, 3);
    botoes = 0; step();

    // Multi-button press, then one button held
    botoes = 4'b0101; pc = 0; ic = 0;
    step(); pc += obs_feita; ic += obs_inv;
    botoes = 4'b0100;
    repeat (3) begin step(); pc += obs_feita; ic += obs_inv; end
    check("multi_pulse_count", pc, 1);
    check("multi_invalid_count", ic, 1);
    botoes = 0; step();

    // Fill every RAM location with a random one-hot play
    clr(); zeraE = 1; step(); clr();
    for (int a = 0; a < DEPTH; a++) begin
      botoes = NB'(1) << $urandom_range(0, NB - 1); registraR = 1; step(); clr();
      botoes = 0; escreveM = 1; contaE = 1; step(); clr();
    end

    // Record 0010 at address 3, then read it back
    zeraE = 1; step(); clr();
    contaE = 1; repeat (3) step(); clr();
    botoes = 4'b0010; registraR = 1; step(); clr();
    botoes = 0; escreveM = 1; step(); clr();
    contaE = 1; step(); clr();
    zeraE = 1; step(); clr();
    contaE = 1; repeat (3) step(); clr();
    step();
    check("readback_mem", int'(db_memoria), 2);
    botoes = 4'b0010; registraR = 1; step(); clr();
    check("cmp_equal", int'(chavesIgualMemoria), 1);
    botoes = 4'b1000; registraR = 1; step(); clr();
    check("cmp_differ", int'(chavesIgualMemoria), 0);
    botoes = 0; step();

    // Address wrap and zera priority
    zeraE = 1; step(); clr();
    for (int i = 1; i <= DEPTH; i++) begin
      contaE = 1; step(); clr();
      if (i == DEPTH - 1) check("wrap_fimE_at_last", int'(fimE), 1);
      if (i == DEPTH) check("wrap_addr_zero", int'(db_contagem), 0);
    end
    contaE = 1; step();
    zeraE = 1;
    repeat (3) begin step(); check("zera_over_conta", int'(db_contagem), 0); end
    clr();

    // Limit compare with limit = 2
    zeraL = 1; step(); clr();
    contaL = 1; repeat (2) step(); clr();
    zeraE = 1; step(); clr();
    for (int a = 0; a < 4; a++) begin
      check("lim_le", int'(enderecoMenorOuIgualLimite), int'(a <= 2));
      check("lim_eq", int'(enderecoIgualLimite), int'(a == 2));
      contaE = 1; step(); clr();
    end

    // Idle timeout, sticky, cleared by a press
    botoes = 0; zeraE = 1; step(); clr();
    for (int i = 1; i <= TIMEOUT_CYC - 1; i++) begin
      step();
      if (i == TIMEOUT_CYC - 2) check("timeout_not_yet", int'(timeout), 0);
    end
    check("timeout_set", int'(timeout), 1);
    repeat (10) step();
    check("timeout_sticky", int'(timeout), 1);
    botoes = 4'b0001; step();
    check("timeout_cleared", int'(timeout), 0);
    botoes = 0; step();

    // Display timer period
    zeraTMR = 1; step(); clr();
    contaTMR = 1; pc = 0;
    repeat (15) begin step(); pc += int'(fimTMR); end
    check("tmr_fim_count", pc, 3);
    clr();

    // Randomised strobes and buttons
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 0)
        botoes = ($urandom_range(0, 2) == 0) ? NB'($urandom_range(0, 15)) : '0;
      zeraE     = ($urandom_range(0, 15) == 0);
      contaE    = ($urandom_range(0, 3) == 0);
      zeraL     = ($urandom_range(0, 15) == 0);
      contaL    = ($urandom_range(0, 3) == 0);
      zeraR     = ($urandom_range(0, 15) == 0);
      registraR = ($urandom_range(0, 3) == 0);
      escreveM  = ($urandom_range(0, 3) == 0);
      zeraTMR   = ($urandom_range(0, 15) == 0);
      contaTMR  = ($urandom_range(0, 1) == 0);
      step();
    end
    clr();

    // Button held through reset gives a pulse right after reset
    botoes = 4'b0001; reset = 1; step();
    reset = 0; step();
    check("held_through_reset_pulse", int'(obs_feita), 1);
    step();
    check("held_no_second_pulse", int'(obs_feita), 0);
    botoes = 0; step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fluxo_dados_genius_n.md
Name: fluxo_dados_genius_n

Overview:
Parametrised datapath for the memory-sequence game, generalised over button count, sequence depth and timer lengths. It replaces the fixed ROM with a DEPTH x NB synchronous RAM, so the controller can record new plays. It adds invalid-play detection for multiple buttons pressed at once, and all clears are synchronous. It sits under the game's control unit, which drives every zera/conta/registra/escreve strobe and consumes the status flags.

Parameters:
NB, 4, number of buttons; the play width, one-hot.
DEPTH, 16, sequence memory depth; must be 2 or more.
AW, $clog2(DEPTH), address/limit counter width.
TIMEOUT_CYC, 5000, idle clock cycles before timeout.
TMR_CYC, 500, period of the display timer in clock cycles.

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high; clears all registers except RAM contents
botoes  in  NB  raw button levels, already synchronised
zeraE, contaE  in  1  address counter clear / increment
zeraL, contaL  in  1  limit counter clear / increment
zeraR, registraR  in  1  play register clear / load
escreveM  in  1  write play register into RAM at current address
zeraTMR, contaTMR  in  1  display timer clear / count enable
fimE, fimL, fimTMR  out  1  address at DEPTH-1 / limit at DEPTH-1 / timer at TMR_CYC-1
jogada_feita  out  1  one-cycle pulse on a button press
jogada_invalida  out  1  one-cycle pulse, only together with jogada_feita
chavesIgualMemoria  out  1  play register equals RAM read data
enderecoIgualLimite  out  1  address == limit
enderecoMenorOuIgualLimite  out  1  address <= limit
timeout  out  1  sticky idle flag
db_jogada, db_memoria  out  NB  play register, RAM read data
db_contagem, db_limite  out  AW  address, limit
db_tem_jogada  out  1  any button high

Behaviour:
- Reset values: address=0, limit=0, play register=0, RAM read register=0, edge register=0, idle counter=0, timeout=0, timer=0.
- Flags after reset: jogada_feita=0, chavesIgualMemoria=1 (0==0), enderecoIgualLimite=1, enderecoMenorOuIgualLimite=1, fimE=fimL=fimTMR=0.
- Address and limit counters:
  - Modulo DEPTH; zera has priority over conta.
  - conta at DEPTH-1 wraps to 0.
  - fimE/fimL are combinational decodes of count==DEPTH-1.
- Play register: reset or zeraR gives 0 (clear has priority); otherwise registraR loads botoes.
- RAM:
  - escreveM writes mem[address] <= play register at the clock edge.
  - Read register loads mem[address] every cycle, so read latency is one cycle after an address change.
  - On a same-cycle write to the current address, the read register takes the written value (write-through).
  - RAM contents are not cleared by reset and are undefined until written.
- Comparators are combinational: chavesIgualMemoria = (play register == read register); the address/limit compares are unsigned.
- Edge detector:
  - tem = |botoes; prev <= tem each cycle.
  - jogada_feita = tem & ~prev, so it is exactly 1 cycle per press, whatever the hold length.
  - jogada_invalida = jogada_feita & (popcount(botoes) > 1).
  - Reset forces prev=0; a button held through reset therefore yields a pulse on the first cycle after reset.
- Idle counter:
  - Cleared synchronously by reset, zeraE, contaE or jogada_feita (clear wins).
  - Otherwise it increments while tem==0 and timeout==0; it holds while a button is down.
  - timeout is set on the edge where the count reaches TIMEOUT_CYC-1, stays 1 until cleared, and the counter freezes while it is set.
- Display timer:
  - reset or zeraTMR clears it (priority); contaTMR increments it modulo TMR_CYC.
  - fimTMR = (count == TMR_CYC-1), combinational.
- Debug outputs are direct copies of the internal registers and tem.

Test Plan (NB=4, DEPTH=8, TIMEOUT_CYC=20, TMR_CYC=5):
- Reset, then botoes=0001 for 3 cycles → jogada_feita high exactly 1 cycle; jogada_invalida=0; db_tem_jogada=1 for 3 cycles.
- botoes=0101 rising → jogada_feita and jogada_invalida both pulse for 1 cycle; botoes=0100 held afterwards → no further pulse.
- Record and compare:
  - Load 0010, set escreveM at address 3, then contaE.
  - Return with zeraE and 3x contaE → one cycle later db_memoria=0010.
  - registraR with 0010 → chavesIgualMemoria=1; with 1000 → 0.
- Address wrap: contaE x8 from 0 → fimE=1 at 7, address=0 after the 8th increment; contaE held together with zeraE → address stays 0.
- Limit compare: limit=2 → enderecoMenorOuIgualLimite=1 for address 0..2 and 0 at 3; enderecoIgualLimite=1 only at 2.
- Timers:
  - Idle 19 cycles after zeraE → timeout=1 and stays 1 for 10 more cycles.
  - A button press then clears it the next cycle.
  - contaTMR held → fimTMR pulses every 5th cycle.
